// File: rtl/fetch_resp_filter_pkg.sv
// Shared memory-message types for the fetch response filter.
// mem_req_4B_t / mem_resp_4B_t set the default widths of the request and
// response channels that pass through the filter unchanged.
package fetch_resp_filter_pkg;

   typedef logic [76:0] mem_req_4B_t;
   typedef logic [46:0] mem_resp_4B_t;

endpackage

// File: rtl/fetch_resp_filter_if.sv
// Valid/ready message channel used on all four sides of the filter.
//   msg : payload, driven by the master
//   val : payload valid, driven by the master
//   rdy : consumer ready, driven by the slave
interface fetch_resp_filter_if
   import fetch_resp_filter_pkg::*;
#(
   parameter int p_nbits = $bits(mem_req_4B_t)
);

   logic [p_nbits-1:0] msg;
   logic               val;
   logic               rdy;

   modport master (output msg, output val, input rdy);
   modport slave  (input msg, input val, output rdy);

endinterface

// File: rtl/fetch_inflight_tracker.sv
// Circular buffer of per-request stale bits for outstanding imem requests.
//   enq        : a request was issued to imem this cycle
//   deq        : the head response was consumed this cycle
//   squash     : mark every entry valid before this cycle's enqueue stale
//   head_stale : stored stale bit of the oldest outstanding request
//   full/empty : occupancy flags
//   count      : number of outstanding requests (registered)
module fetch_inflight_tracker #(
   parameter int  p_max_inflight = 2,
   localparam int p_cnt_nbits    = $clog2(p_max_inflight + 1),
   localparam int p_ptr_nbits    = (p_max_inflight > 1) ? $clog2(p_max_inflight) : 1
)(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enq,
   input  logic                   deq,
   input  logic                   squash,
   output logic                   head_stale,
   output logic                   full,
   output logic                   empty,
   output logic [p_cnt_nbits-1:0] count
);

   typedef logic [p_ptr_nbits-1:0] ptr_t;

   logic [p_max_inflight-1:0] valid_r;
   logic [p_max_inflight-1:0] stale_r;
   ptr_t                      head_r;
   ptr_t                      tail_r;
   logic [p_cnt_nbits-1:0]    count_r;

   // Pointers wrap explicitly so non-power-of-two depths work.
   function automatic ptr_t ptr_incr(input ptr_t ptr);
      ptr_t nxt;
      if (ptr == ptr_t'(p_max_inflight - 1)) begin
         nxt = '0;
      end else begin
         nxt = ptr + ptr_t'(1);
      end
      return nxt;
   endfunction

   // Entry state, pointers and occupancy count.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_r <= '0;
         stale_r <= '0;
         head_r  <= '0;
         tail_r  <= '0;
         count_r <= '0;
      end else begin
         // Squash only reaches entries already valid; the entry written by a
         // same-cycle enqueue is cleared below and so stays on the new path.
         if (squash) begin
            stale_r <= stale_r | valid_r;
         end
         if (deq) begin
            valid_r[head_r] <= 1'b0;
            head_r          <= ptr_incr(head_r);
         end
         if (enq) begin
            valid_r[tail_r] <= 1'b1;
            stale_r[tail_r] <= 1'b0;
            tail_r          <= ptr_incr(tail_r);
         end
         case ({enq, deq})
            2'b10:   count_r <= count_r + p_cnt_nbits'(1);
            2'b01:   count_r <= count_r - p_cnt_nbits'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Status decode from registered state.
   always_comb begin
      head_stale = stale_r[head_r];
      full       = (count_r == p_cnt_nbits'(p_max_inflight));
      empty      = (count_r == p_cnt_nbits'(0));
      count      = count_r;
   end

endmodule

// File: rtl/fetch_resp_filter_chk.sv
// Protocol checker: flags an imem response arriving while nothing is
// outstanding. The block tolerates this (and records it in err), so it is
// reported as a warning rather than a hard error.
//   clk, reset : clock and synchronous reset
//   resp_val   : imem response valid
//   empty      : no requests outstanding
module fetch_resp_filter_chk (
   input logic clk,
   input logic reset,
   input logic resp_val,
   input logic empty
);

   // Sample the orphan-response condition on every active edge.
   always @(posedge clk) begin
      if (!reset) begin
         assert (!(resp_val && empty))
            else $warning("imem response with no request outstanding");
      end
   end

endmodule

// File: rtl/fetch_resp_filter.sv
// Fetch/imem response filter. Tracks up to p_max_inflight outstanding
// requests; a squash makes all of them stale so their responses are consumed
// from imem without reaching fetch.
//   clk, reset   : clock, synchronous active-high reset
//   squash       : redirect pulse
//   req_in       : requests from fetch (slave)
//   req_out      : requests to imem (master), combinational pass-through
//   resp_in      : responses from imem (slave)
//   resp_out     : responses to fetch (master), combinational pass-through
//   num_inflight : outstanding request count
//   num_dropped  : stale responses discarded (wraps)
//   err          : sticky, a response arrived with nothing outstanding
module fetch_resp_filter
   import fetch_resp_filter_pkg::*;
#(
   parameter int  p_max_inflight    = 2,
   parameter int  p_req_nbits       = $bits(mem_req_4B_t),
   parameter int  p_resp_nbits      = $bits(mem_resp_4B_t),
   parameter bit  p_squash_head_now = 1'b1,
   parameter int  p_cnt_nbits       = 32,
   localparam int p_inflight_nbits  = $clog2(p_max_inflight + 1)
)(
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        squash,
   fetch_resp_filter_if.slave          req_in,
   fetch_resp_filter_if.master         req_out,
   fetch_resp_filter_if.slave          resp_in,
   fetch_resp_filter_if.master         resp_out,
   output logic [p_inflight_nbits-1:0] num_inflight,
   output logic [p_cnt_nbits-1:0]      num_dropped,
   output logic                        err
);

   logic                        enq_s;
   logic                        deq_s;
   logic                        drop_s;
   logic                        orphan_s;
   logic                        head_stale_raw_s;
   logic                        head_stale_s;
   logic                        full_s;
   logic                        empty_s;
   logic [p_inflight_nbits-1:0] count_s;
   logic [p_cnt_nbits-1:0]      num_dropped_r;
   logic                        err_r;

   fetch_inflight_tracker #(
      .p_max_inflight (p_max_inflight)
   ) u_tracker (
      .clk        (clk),
      .reset      (reset),
      .enq        (enq_s),
      .deq        (deq_s),
      .squash     (squash),
      .head_stale (head_stale_raw_s),
      .full       (full_s),
      .empty      (empty_s),
      .count      (count_s)
   );

   fetch_resp_filter_chk u_chk (
      .clk      (clk),
      .reset    (reset),
      .resp_val (resp_in.val),
      .empty    (empty_s)
   );

   assign req_out.msg  = req_in.msg;
   assign resp_out.msg = resp_in.msg;

   // Request gating depends only on occupancy, never on the response path.
   always_comb begin
      req_out.val = req_in.val && !full_s;
      req_in.rdy  = req_out.rdy && !full_s;
      enq_s       = req_in.val && req_out.rdy && !full_s;
   end

   // Response steering: drop stale heads and orphans, pass live heads.
   always_comb begin
      head_stale_s = head_stale_raw_s || (squash && p_squash_head_now);
      resp_in.rdy  = 1'b1;
      resp_out.val = 1'b0;
      deq_s        = 1'b0;
      drop_s       = 1'b0;
      orphan_s     = 1'b0;
      if (empty_s) begin
         orphan_s = resp_in.val;
      end else if (head_stale_s) begin
         deq_s  = resp_in.val;
         drop_s = resp_in.val;
      end else begin
         resp_out.val = resp_in.val;
         resp_in.rdy  = resp_out.rdy;
         deq_s        = resp_in.val && resp_out.rdy;
      end
   end

   // Drop statistics and sticky protocol error.
   always_ff @(posedge clk) begin
      if (reset) begin
         num_dropped_r <= '0;
         err_r         <= 1'b0;
      end else begin
         if (drop_s) begin
            num_dropped_r <= num_dropped_r + p_cnt_nbits'(1);
         end
         if (orphan_s) begin
            err_r <= 1'b1;
         end
      end
   end

   assign num_inflight = count_s;
   assign num_dropped  = num_dropped_r;
   assign err          = err_r;

endmodule

// File: tb/tb_fetch_resp_filter.sv
module tb_fetch_resp_filter;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic squash = 1'b0;

   always #5 clk = ~clk;

   // Instance a: squash drops a head presented in the squash cycle.
   fetch_resp_filter_if #(.p_nbits(77)) req_in_a   ();
   fetch_resp_filter_if #(.p_nbits(77)) req_out_a  ();
   fetch_resp_filter_if #(.p_nbits(47)) resp_in_a  ();
   fetch_resp_filter_if #(.p_nbits(47)) resp_out_a ();
   logic [1:0]  num_inflight_a;
   logic [31:0] num_dropped_a;
   logic        err_a;

   // Instance b: same stimulus, head presented in the squash cycle survives.
   fetch_resp_filter_if #(.p_nbits(77)) req_in_b   ();
   fetch_resp_filter_if #(.p_nbits(77)) req_out_b  ();
   fetch_resp_filter_if #(.p_nbits(47)) resp_in_b  ();
   fetch_resp_filter_if #(.p_nbits(47)) resp_out_b ();
   logic [1:0]  num_inflight_b;
   logic [31:0] num_dropped_b;
   logic        err_b;

   fetch_resp_filter #(.p_squash_head_now(1'b1)) dut_a (
      .clk(clk), .reset(reset), .squash(squash),
      .req_in(req_in_a), .req_out(req_out_a), .resp_in(resp_in_a), .resp_out(resp_out_a),
      .num_inflight(num_inflight_a), .num_dropped(num_dropped_a), .err(err_a)
   );

   fetch_resp_filter #(.p_squash_head_now(1'b0)) dut_b (
      .clk(clk), .reset(reset), .squash(squash),
      .req_in(req_in_b), .req_out(req_out_b), .resp_in(resp_in_b), .resp_out(resp_out_b),
      .num_inflight(num_inflight_b), .num_dropped(num_dropped_b), .err(err_b)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] mem_q[$];   // requests accepted by imem, in order
   logic [46:0] exp_q[$];   // responses fetch must see, in order

   logic        obs_req_val, obs_req_rdy, obs_out_val, obs_in_rdy;
   logic        obs_out_val_b;
   logic [46:0] obs_out_msg_b;
   logic [31:0] drop_a0, drop_b0;

   task automatic chk_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [46:0] resp_of(input logic [31:0] addr);
      return {15'h1ab5, addr};
   endfunction

   task automatic idle_inputs();
      squash = 1'b0;
      req_in_a.val = 1'b0;  req_in_b.val = 1'b0;
      req_in_a.msg = '0;    req_in_b.msg = '0;
      resp_in_a.val = 1'b0; resp_in_b.val = 1'b0;
      resp_in_a.msg = '0;   resp_in_b.msg = '0;
   endtask

   // One clock: drive at negedge, observe before posedge, settle after it.
   // The imem model returns the oldest accepted request when rsv is set,
   // or an orphan word when nothing was accepted.
   task automatic cyc(input logic sq, input logic rqv, input logic [31:0] addr,
                      input logic rsv, input logic dlv);
      logic [46:0] rmsg;
      @(negedge clk);
      rmsg = (mem_q.size() > 0) ? resp_of(mem_q[0]) : 47'h0dead;
      squash = sq;
      req_in_a.val = rqv;  req_in_b.val = rqv;
      req_in_a.msg = {45'd0, addr}; req_in_b.msg = {45'd0, addr};
      resp_in_a.val = rsv; resp_in_b.val = rsv;
      resp_in_a.msg = rmsg; resp_in_b.msg = rmsg;
      #3;
      obs_req_val   = req_out_a.val;
      obs_req_rdy   = req_in_a.rdy;
      obs_out_val   = resp_out_a.val;
      obs_in_rdy    = resp_in_a.rdy;
      obs_out_val_b = resp_out_b.val;
      obs_out_msg_b = resp_out_b.msg;
      if (resp_out_a.val && resp_out_a.rdy) begin
         if (exp_q.size() == 0) begin
            chk_eq("resp_unexpected", {127'd0, obs_out_val}, 128'd0);
         end else begin
            chk_eq("resp_msg", {81'd0, resp_out_a.msg}, {81'd0, exp_q.pop_front()});
         end
      end
      if (resp_in_a.val && resp_in_a.rdy && mem_q.size() > 0) begin
         mem_q.delete(0);
      end
      if (req_out_a.val && req_out_a.rdy) begin
         chk_eq("req_out_msg", {51'd0, req_out_a.msg}, {96'd0, addr});
         mem_q.push_back(addr);
         if (dlv) exp_q.push_back(resp_of(addr));
      end
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      reset = 1'b1;
      idle_inputs();
      repeat (n) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      idle_inputs();
      req_out_a.rdy = 1'b1;  req_out_b.rdy = 1'b1;
      resp_out_a.rdy = 1'b1; resp_out_b.rdy = 1'b1;
      do_reset(2);

      // Reset state
      chk_eq("rst_inflight", 128'(num_inflight_a), 128'd0);
      chk_eq("rst_dropped",  128'(num_dropped_a),  128'd0);
      chk_eq("rst_err",      128'(err_a),          128'd0);
      chk_eq("rst_req_rdy",  128'(req_in_a.rdy),   128'd1);

      // Two back-to-back requests, delivered in order
      cyc(1'b0, 1'b1, 32'h100, 1'b0, 1'b1);
      chk_eq("t1_inflight_1", 128'(num_inflight_a), 128'd1);
      cyc(1'b0, 1'b1, 32'h104, 1'b0, 1'b1);
      chk_eq("t1_inflight_2", 128'(num_inflight_a), 128'd2);
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      chk_eq("t1_inflight_3", 128'(num_inflight_a), 128'd1);
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      chk_eq("t1_inflight_4", 128'(num_inflight_a), 128'd0);
      chk_eq("t1_dropped",    128'(num_dropped_a),  128'd0);

      // Squash two outstanding, then a new-path request to 0x200
      cyc(1'b0, 1'b1, 32'h110, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 32'h114, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 32'h0,   1'b0, 1'b0);
      cyc(1'b0, 1'b1, 32'h200, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      chk_eq("t2_drop1_outval", 128'(obs_out_val), 128'd0);
      chk_eq("t2_drop1_inrdy",  128'(obs_in_rdy),  128'd1);
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      chk_eq("t2_drop2_outval", 128'(obs_out_val), 128'd0);
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      chk_eq("t2_dropped",  128'(num_dropped_a),  128'd2);
      chk_eq("t2_inflight", 128'(num_inflight_a), 128'd0);

      // Squash in the same cycle as the enqueue of 0x300
      cyc(1'b0, 1'b1, 32'h120, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 32'h300, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      chk_eq("t3_drop_outval", 128'(obs_out_val), 128'd0);
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      chk_eq("t3_deliver_outval", 128'(obs_out_val), 128'd1);
      chk_eq("t3_dropped", 128'(num_dropped_a), 128'd3);

      // Response in the squash cycle with a live head: a drops, b delivers
      drop_a0 = num_dropped_a;
      drop_b0 = num_dropped_b;
      cyc(1'b0, 1'b1, 32'h130, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
      chk_eq("t4_a_outval",  128'(obs_out_val), 128'd0);
      chk_eq("t4_a_dropped", 128'(num_dropped_a), 128'(drop_a0 + 32'd1));
      chk_eq("t4_b_outval",  128'(obs_out_val_b), 128'd1);
      chk_eq("t4_b_msg",     128'(obs_out_msg_b), 128'(resp_of(32'h130)));
      chk_eq("t4_b_dropped", 128'(num_dropped_b), 128'(drop_b0));
      chk_eq("t4_b_inflight", 128'(num_inflight_b), 128'd0);

      // Full tracker back-pressures fetch until a response dequeues
      cyc(1'b0, 1'b1, 32'h140, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 32'h144, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 32'h148, 1'b0, 1'b1);
      chk_eq("t5_full_rdy", 128'(obs_req_rdy), 128'd0);
      chk_eq("t5_full_val", 128'(obs_req_val), 128'd0);
      cyc(1'b0, 1'b1, 32'h148, 1'b1, 1'b1);
      chk_eq("t5_nobypass_rdy", 128'(obs_req_rdy), 128'd0);
      chk_eq("t5_inflight_1", 128'(num_inflight_a), 128'd1);
      cyc(1'b0, 1'b1, 32'h148, 1'b1, 1'b1);
      chk_eq("t5_accept_rdy", 128'(obs_req_rdy), 128'd1);
      chk_eq("t5_inflight_2", 128'(num_inflight_a), 128'd1);
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      chk_eq("t5_inflight_0", 128'(num_inflight_a), 128'd0);

      // Orphan response, then reset with one request outstanding
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      chk_eq("t6_orphan_outval", 128'(obs_out_val), 128'd0);
      chk_eq("t6_orphan_inrdy",  128'(obs_in_rdy),  128'd1);
      chk_eq("t6_err", 128'(err_a), 128'd1);
      chk_eq("t6_dropped_same", 128'(num_dropped_a), 128'd4);
      cyc(1'b0, 1'b1, 32'h150, 1'b0, 1'b0);
      chk_eq("t6_inflight_pre", 128'(num_inflight_a), 128'd1);
      do_reset(1);
      chk_eq("t6_rst_err",      128'(err_a),          128'd0);
      chk_eq("t6_rst_inflight", 128'(num_inflight_a), 128'd0);
      chk_eq("t6_rst_dropped",  128'(num_dropped_a),  128'd0);
      cyc(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      chk_eq("t6_late_outval", 128'(obs_out_val), 128'd0);
      chk_eq("t6_late_err", 128'(err_a), 128'd1);
      chk_eq("t6_late_dropped", 128'(num_dropped_a), 128'd0);

      chk_eq("exp_q_drained", 128'(exp_q.size()), 128'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
